// File: rtl/button_gen_pkg.sv
// Shared definitions for the button press generator.
// Kind codes, FSM states and LFSR constants.
package button_gen_pkg;

  localparam logic [1:0] KIND_SHORT  = 2'd0;
  localparam logic [1:0] KIND_LONG   = 2'd1;
  localparam logic [1:0] KIND_DOUBLE = 2'd2;
  localparam logic [1:0] KIND_RSVD   = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PRESS1   = 3'd1,
    ST_GAP      = 3'd2,
    ST_PRESS2   = 3'd3,
    ST_COOLDOWN = 3'd4,
    ST_FINISH   = 3'd5
  } state_t;

  // x^8+x^6+x^5+x^4+1, shifting left, taps on bits 7,5,4,3
  localparam logic [7:0] LFSR_SEED = 8'hA5;
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  function automatic logic [7:0] lfsr_step(
    input logic [7:0] q
  );
    return {q[6:0], ^(q & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/lfsr8.sv
// 8-bit Fibonacci LFSR used to model contact bounce.
// Exposes the value the register takes on the next edge.
module lfsr8
  import button_gen_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] q_next
);

  logic [7:0] q;

  assign q_next = lfsr_step(q);

  // free-running shift register, reseeded on reset
  always_ff @(posedge clk) begin
    if (rst) q <= LFSR_SEED;
    else     q <= q_next;
  end

endmodule

// File: rtl/button_press_gen.sv
// Button press waveform generator: short, long, double presses.
// Optional contact bounce via BUTTON_PRESS_GEN_BOUNCE_EN.
module button_press_gen
  import button_gen_pkg::*;
#(
  parameter int unsigned SHORT_CYC  = 4,
  parameter int unsigned LONG_CYC   = 10,
  parameter int unsigned GAP_CYC    = 3,
  parameter int unsigned BOUNCE_CYC = 2
)(
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  input  logic [1:0] req_kind,
  output logic       req_ready,
  output logic       button,
  output logic       done,
  output logic       err
);

  localparam logic [15:0] SHORT_LD = 16'(SHORT_CYC - 1);
  localparam logic [15:0] LONG_LD  = 16'(LONG_CYC - 1);
  localparam logic [15:0] GAP_LD   = 16'(GAP_CYC - 1);

  state_t      state, state_d;
  logic [15:0] cnt, cnt_d;
  logic [1:0]  kind, kind_d;
  logic        button_d, done_d, err_d;
  logic        accept, cnt_zero, press_d;

  assign req_ready = (state == ST_IDLE) || (state == ST_FINISH);
  assign accept    = req_valid && req_ready;
  assign cnt_zero  = (cnt == 16'd0);

  // next state, phase counter and captured kind
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    kind_d  = kind;
    unique case (state)
      ST_IDLE, ST_FINISH: begin
        state_d = ST_IDLE;
        if (accept) begin
          kind_d = req_kind;
          unique case (req_kind)
            KIND_SHORT: begin
              state_d = ST_PRESS1;
              cnt_d   = SHORT_LD;
            end
            KIND_LONG: begin
              state_d = ST_PRESS1;
              cnt_d   = LONG_LD;
            end
            KIND_DOUBLE: begin
              state_d = ST_PRESS1;
              cnt_d   = SHORT_LD;
            end
            default: begin
              state_d = ST_FINISH;
              cnt_d   = 16'd0;
            end
          endcase
        end
      end
      ST_PRESS1: begin
        if (!cnt_zero) begin
          cnt_d = cnt - 16'd1;
        end else if (kind == KIND_DOUBLE) begin
          state_d = ST_GAP;
          cnt_d   = GAP_LD;
        end else begin
          state_d = ST_COOLDOWN;
          cnt_d   = GAP_LD;
        end
      end
      ST_GAP: begin
        if (!cnt_zero) begin
          cnt_d = cnt - 16'd1;
        end else begin
          state_d = ST_PRESS2;
          cnt_d   = SHORT_LD;
        end
      end
      ST_PRESS2: begin
        if (!cnt_zero) begin
          cnt_d = cnt - 16'd1;
        end else begin
          state_d = ST_COOLDOWN;
          cnt_d   = GAP_LD;
        end
      end
      ST_COOLDOWN: begin
        if (!cnt_zero) begin
          cnt_d = cnt - 16'd1;
        end else begin
          state_d = ST_FINISH;
          cnt_d   = 16'd0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 16'd0;
      end
    endcase
  end

  assign press_d = (state_d == ST_PRESS1) ||
                   (state_d == ST_PRESS2);

`ifdef BUTTON_PRESS_GEN_BOUNCE_EN
  logic [7:0]  lfsr_next;
  logic [16:0] len_d;
  logic        bounce_d;

  lfsr8 u_lfsr (
    .clk    (clk),
    .rst    (rst),
    .q_next (lfsr_next)
  );

  // early cycles of a press phase follow the LFSR bit
  always_comb begin
    len_d = 17'(SHORT_CYC);
    if ((state_d == ST_PRESS1) && (kind_d == KIND_LONG))
      len_d = 17'(LONG_CYC);
    bounce_d = ({1'b0, cnt_d} + 17'(BOUNCE_CYC)) >= len_d;
    button_d = press_d && (bounce_d ? lfsr_next[0] : 1'b1);
  end
`else
  logic unused_bounce;
  assign unused_bounce = (BOUNCE_CYC != 0);

  // solid press level
  always_comb begin
    button_d = press_d;
  end
`endif

  // completion pulse and reserved-kind flag for the next cycle
  always_comb begin
    done_d = (state_d == ST_FINISH);
    err_d  = done_d && (kind_d == KIND_RSVD);
  end

  // state and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      cnt    <= 16'd0;
      kind   <= KIND_SHORT;
      button <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
    end else begin
      state  <= state_d;
      cnt    <= cnt_d;
      kind   <= kind_d;
      button <= button_d;
      done   <= done_d;
      err    <= err_d;
    end
  end

endmodule

// File: tb/tb_button_press_gen.sv
// Self-checking bench for button_press_gen.
// Table-driven requests plus hand sequences, queue scoreboard.
module tb_button_press_gen;

  localparam int SC  = 4;
  localparam int LC  = 10;
  localparam int GC  = 3;
  localparam int BNC = 2;

  logic       clk;
  logic       rst;
  logic       req_valid;
  logic [1:0] req_kind;
  logic       req_ready;
  logic       button;
  logic       done;
  logic       err;

  button_press_gen #(
    .SHORT_CYC  (SC),
    .LONG_CYC   (LC),
    .GAP_CYC    (GC),
    .BOUNCE_CYC (BNC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_kind  (req_kind),
    .req_ready (req_ready),
    .button    (button),
    .done      (done),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference bounce LFSR, x^8+x^6+x^5+x^4+1 from seed A5
  logic [7:0] m_lfsr;
  always @(posedge clk) begin
    if (rst) m_lfsr <= 8'hA5;
    else     m_lfsr <= {m_lfsr[6:0],
                        m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
  end

  typedef struct {
    logic b;
    logic d;
    logic e;
    logic r;
    logic bnc;
  } exp_t;

  typedef struct {
    logic [1:0] kind;
    int         hi1;
    int         gap;
    int         hi2;
    int         cool;
    logic       err;
  } vec_t;

  exp_t  sbq[$];
  vec_t  vecs[6];
  int    checks;
  int    errors;
  string cur;

  task automatic push(input logic b, input logic d,
                      input logic e, input logic r,
                      input logic bnc);
    exp_t x;
    x.b = b; x.d = d; x.e = e; x.r = r; x.bnc = bnc;
    sbq.push_back(x);
  endtask

  task automatic push_idle();
    push(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic build(input vec_t v);
    logic bz;
    for (int j = 0; j < v.hi1; j++) begin
      bz = 1'b0;
`ifdef BUTTON_PRESS_GEN_BOUNCE_EN
      bz = (j < BNC);
`endif
      push(1'b1, 1'b0, 1'b0, 1'b0, bz);
    end
    for (int j = 0; j < v.gap; j++)
      push(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int j = 0; j < v.hi2; j++) begin
      bz = 1'b0;
`ifdef BUTTON_PRESS_GEN_BOUNCE_EN
      bz = (j < BNC);
`endif
      push(1'b1, 1'b0, 1'b0, 1'b0, bz);
    end
    for (int j = 0; j < v.cool; j++)
      push(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    push(1'b0, 1'b1, v.err, 1'b1, 1'b0);
  endtask

  // one clock edge, then compare the next expected cycle
  task automatic step_check();
    exp_t x;
    logic eb;
    @(posedge clk);
    #1;
    checks++;
    if (sbq.size() == 0) begin
      errors++;
      $display("FAIL %s scoreboard empty at %0t", cur, $time);
    end else begin
      x  = sbq.pop_front();
      eb = x.bnc ? m_lfsr[0] : x.b;
      if (button !== eb || done !== x.d ||
          err !== x.e || req_ready !== x.r) begin
        errors++;
        $display("FAIL %s t=%0t got b%0b d%0b e%0b r%0b want b%0b d%0b e%0b r%0b",
                 cur, $time, button, done, err, req_ready,
                 eb, x.d, x.e, x.r);
      end
    end
  endtask

  task automatic drain();
    int n;
    n = sbq.size();
    for (int j = 0; j < n; j++) step_check();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout at %0t", $time);
    $fatal(1);
  end

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_kind  = 2'd0;

    vecs[0] = '{2'd0, SC, 0, 0,  GC, 1'b0};
    vecs[1] = '{2'd1, LC, 0, 0,  GC, 1'b0};
    vecs[2] = '{2'd2, SC, GC, SC, GC, 1'b0};
    vecs[3] = '{2'd3, 0,  0, 0,  0,  1'b1};
    vecs[4] = '{2'd2, SC, GC, SC, GC, 1'b0};
    vecs[5] = '{2'd0, SC, 0, 0,  GC, 1'b0};

    // reset state
    cur = "reset";
    push_idle();
    push_idle();
    drain();
    rst = 1'b0;
    push_idle();
    drain();

    // table of single requests, each followed by one idle cycle
    for (int i = 0; i < 6; i++) begin
      cur = $sformatf("vec%0d_kind%0d", i, vecs[i].kind);
      req_valid = 1'b1;
      req_kind  = vecs[i].kind;
      build(vecs[i]);
      push_idle();
      step_check();
      req_valid = 1'b0;
      drain();
    end

    // long with valid held: ignored while busy, short accepted at FINISH
    cur = "hold_b2b";
    req_valid = 1'b1;
    req_kind  = 2'd1;
    build(vecs[1]);
    build(vecs[0]);
    push_idle();
    step_check();
    req_kind = 2'd0;
    for (int j = 0; j < LC + GC + 1; j++) step_check();
    req_valid = 1'b0;
    drain();

    // reserved kind back-to-back with itself
    cur = "rsvd_b2b";
    req_valid = 1'b1;
    req_kind  = 2'd3;
    push(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    push(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    push_idle();
    step_check();
    step_check();
    req_valid = 1'b0;
    drain();

    // reset during a long press: abort, no done afterwards
    cur = "rst_mid_long";
    req_valid = 1'b1;
    req_kind  = 2'd1;
    push(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step_check();
    req_valid = 1'b0;
    rst       = 1'b1;
    push_idle();
    step_check();
    rst = 1'b0;
    for (int j = 0; j < LC + GC + 4; j++) push_idle();
    drain();

    // reset wins over a request in the same cycle
    cur = "rst_priority";
    rst       = 1'b1;
    req_valid = 1'b1;
    req_kind  = 2'd0;
    push_idle();
    step_check();
    rst       = 1'b0;
    req_valid = 1'b0;
    for (int j = 0; j < 3; j++) push_idle();
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
